pipeline_stall_ctrl: RTL

Central stall/flush arbiter for the 5-stage pipeline. It combines the decode-stage data-hazard stall request, the branch/jump flush request, and the instruction- and data-memory busy signals into per-stage latch-enable and bubble-insert controls. It tracks three things:
- a flush that arrives while fetch is blocked, held until fetch resumes;
- a sticky halt;
- saturating performance counters.

It sits beside the pipeline registers and drives their enable and NOP-insert pins.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 14 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush arbiter: FSM encoding and
// default counter sizing.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_PEND = 2'd1,
    HALT       = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_MAX_HAZ = 2;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush arbiter: turns hazard, redirect and memory-busy requests
// into per-stage latch-enable / NOP-insert controls, plus halt and perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_HAZ = DEF_MAX_HAZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_hazard,
  input  logic             flush_req,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_nop,
  output logic             dx_en,
  output logic             dx_nop,
  output logic             xm_en,
  output logic             mw_nop,
  output logic             halted,
  output logic             haz_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Wide enough to hold MAX_HAZ+1 so the overflow condition is observable.
  localparam int HAZ_W = $clog2(MAX_HAZ + 2);

  state_t           r_state;
  state_t           w_next;
  logic             r_halted;
  logic             r_haz_err;
  logic             w_active;
  logic             w_flush_ok;
  logic             w_haz_win;
  logic             w_haz_hold;
  logic [HAZ_W-1:0] w_haz_cnt;

  assign w_active   = (r_state != HALT);
  assign w_flush_ok = w_active && flush_req && !dmem_stall;
  assign w_haz_win  = w_active && !dmem_stall && !flush_req && data_hazard;
  assign w_haz_hold = w_active && dmem_stall;

  assign halted  = r_halted;
  assign haz_err = r_haz_err;

  always_comb begin
    pc_en  = 1'b1;
    fd_en  = 1'b1;
    fd_nop = 1'b0;
    dx_en  = 1'b1;
    dx_nop = 1'b0;
    xm_en  = 1'b1;
    mw_nop = 1'b0;
    w_next = r_state;
    if (rst) begin
      {pc_en, fd_en, dx_en, xm_en} = '0;
      {fd_nop, dx_nop, mw_nop}     = '1;
      w_next                       = RUN;
    end else if (r_state == HALT) begin
      {pc_en, fd_en, dx_en, xm_en} = '0;
    end else begin
      // A data hazard overrides an imem stall: IF/ID must hold, not bubble.
      if (dmem_stall) begin
        {pc_en, fd_en, dx_en, xm_en} = '0;
        mw_nop                       = 1'b1;
      end else if (flush_req) begin
        fd_nop = 1'b1;
        dx_nop = 1'b1;
      end else if (data_hazard) begin
        pc_en  = 1'b0;
        fd_en  = 1'b0;
        dx_nop = 1'b1;
      end else if (imem_stall) begin
        pc_en  = 1'b0;
        fd_nop = 1'b1;
      end
      if (r_state == FLUSH_PEND) begin
        fd_nop = 1'b1;
        w_next = imem_stall ? FLUSH_PEND : RUN;
      end else if (w_flush_ok && imem_stall) begin
        w_next = FLUSH_PEND;
      end
      if (halt_req) begin
        w_next = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_halted  <= 1'b0;
      r_haz_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALT);
      if (w_haz_win && (w_haz_cnt >= HAZ_W'(MAX_HAZ))) begin
        r_haz_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .inc (w_active && !pc_en),
    .clr (rst),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .inc (w_flush_ok),
    .clr (rst),
    .q   (flush_count)
  );

  sat_counter #(.W(HAZ_W)) u_haz_cnt (
    .clk (clk),
    .inc (w_haz_win),
    .clr (rst || !(w_haz_win || w_haz_hold)),
    .q   (w_haz_cnt)
  );

endmodule
